// File: rtl/fpdiv_ctrl.sv
// Sequencer for the Goldschmidt divide datapath: one start runs a seed pass, then
// ITERS refinement passes, then pulses done. Outputs are registered from the next state.
module fpdiv_ctrl #(
    parameter int unsigned ITERS = 6,
    parameter int unsigned CW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic [1:0]    sel_mux4,
    output logic          sel_mux2,
    output logic          en_a,
    output logic          en_b,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEED_N = 3'd1,
        S_SEED_D = 3'd2,
        S_ITER_A = 3'd3,
        S_ITER_B = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // The counter must hold ITERS without wrapping.
    if (ITERS < 1 || ITERS >= (1 << CW)) begin : g_bad_params
        $error("fpdiv_ctrl: ITERS must be in 1..2**CW-1");
    end

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic [1:0]    r_sel_mux4;
    logic          r_sel_mux2;
    logic          r_en_a;
    logic          r_en_b;
    logic          r_busy;
    logic          r_done;

    logic [1:0]    w_sel_mux4;
    logic          w_sel_mux2;
    logic          w_en_a;
    logic          w_en_b;
    logic          w_busy;
    logic          w_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state and pass counter; abort overrides everything outside IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) w_state_nxt = S_SEED_N;
            end
            S_SEED_N: w_state_nxt = S_SEED_D;
            S_SEED_D: begin
                w_state_nxt = S_ITER_A;
                w_cnt_nxt   = CW'(1);
            end
            S_ITER_A: begin
                w_state_nxt = S_ITER_B;
                w_cnt_nxt   = r_cnt;
            end
            S_ITER_B: begin
                if (r_cnt < CW'(ITERS)) begin
                    w_state_nxt = S_ITER_A;
                    w_cnt_nxt   = r_cnt + CW'(1);
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start && !abort) w_state_nxt = S_SEED_N;
                else                 w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    // Datapath controls decoded from the next state so the registered copies track the state.
    always_comb begin
        w_sel_mux4 = 2'b00;
        w_sel_mux2 = 1'b0;
        w_en_a     = 1'b0;
        w_en_b     = 1'b0;
        w_busy     = (w_state_nxt != S_IDLE);
        w_done     = 1'b0;
        case (w_state_nxt)
            S_SEED_N: w_en_a = 1'b1;
            S_SEED_D: begin
                w_sel_mux4 = 2'b01;
                w_en_b     = 1'b1;
            end
            S_ITER_A: begin
                w_sel_mux4 = 2'b10;
                w_sel_mux2 = 1'b1;
                w_en_a     = 1'b1;
            end
            S_ITER_B: begin
                w_sel_mux4 = 2'b11;
                w_sel_mux2 = 1'b1;
                w_en_b     = 1'b1;
            end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel_mux4 <= 2'b00;
            r_sel_mux2 <= 1'b0;
            r_en_a     <= 1'b0;
            r_en_b     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sel_mux4 <= w_sel_mux4;
            r_sel_mux2 <= w_sel_mux2;
            r_en_a     <= w_en_a;
            r_en_b     <= w_en_b;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    assign sel_mux4 = r_sel_mux4;
    assign sel_mux2 = r_sel_mux2;
    assign en_a     = r_en_a;
    assign en_b     = r_en_b;
    assign busy     = r_busy;
    assign done     = r_done;
    assign iter_cnt = r_cnt;

endmodule
